imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered instruction-decode stage for the multicycle RISC-V core, sitting between the instruction register and the control/register-file read logic.
- Accepts a 32-bit instruction plus an immediate-format select over a valid/ready handshake, then presents the registered register indices, opcode fields and the sign/zero-extended immediate.
- Generalises the combinational decoder:
  - XLEN-parametrised immediate output (RV32/RV64).
  - Full immediate-format set (I, S, B, J, U, CSR-Z).
  - Illegal-select flagging.
  - Optional skid entry for full throughput under backpressure.

Parameters:
- XLEN, 32, width of immext; legal values 32 or 64.
- SKID, 1, 1 = two-entry buffer (in_ready independent of out_ready); 0 = single output register.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction/imm_src valid.
- in_ready  out  1  stage can accept.
- instr  in  32  full instruction word.
- imm_src  in  3  immediate format select.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  consumer accepts entry.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- immext  out  XLEN  extended immediate.
- imm_err  out  1  imm_src was an unsupported encoding.

Behaviour:
- Reset (async, reset_n=0): out_valid=0, all field outputs, immext and imm_err = 0, skid entry empty. in_ready=1 one cycle after reset_n deasserts; it is 0 while reset_n=0.
- Handshakes:
  - Input accepted on a clk edge with in_valid & in_ready.
  - Output consumed on a clk edge with out_valid & out_ready.
  - Outputs are stable while out_valid & !out_ready.
- Latency: an accepted instruction appears on the outputs with out_valid=1 in the next cycle. No combinational path from in_* to out_*.
- Immediate extension is computed from instr/imm_src at accept time and registered. s = instr[31], sign-extended to XLEN:
  - 000 I: s-ext instr[31:20].
  - 001 S: s-ext {instr[31:25], instr[11:7]}.
  - 010 B: s-ext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: s-ext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: s-ext {instr[31:12], 12'b0}. Identity for XLEN=32; upper 32 bits = s for XLEN=64.
  - 101 Z: zero-ext instr[19:15] (CSR uimm).
  - 110, 111: immext = 0, imm_err = 1. All other fields decode normally.
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - Simultaneous accept and consume replaces the entry in the same edge.
- SKID=1, states EMPTY / ONE / TWO (main + skid entry):
  - EMPTY: accept -> ONE.
  - ONE: accept & !consume -> TWO (new entry into skid). Accept & consume -> ONE (new entry to main). Consume only -> EMPTY.
  - TWO: in_ready = 0. Consume -> ONE, skid moves to main.
  - in_ready is registered: it equals (state != TWO).
  - Order is strictly FIFO; no entry is dropped or duplicated.
- reset_n asserted mid-transfer discards all buffered entries immediately. No partial output is visible.
- Unknown imm_src never affects in_ready or out_valid.

Test Plan:
- XLEN=32: instr=0xFFF10093, imm_src=000 -> next cycle out_valid=1, rd=1, rs1=2, funct3=0, opcode=0x13, immext=0xFFFFFFFF, imm_err=0.
- instr=0x00512423 (sw x5,8(x2)), imm_src=001 -> immext=0x00000008, rs1=2, rs2=5. Then instr=0xFE000EE3, imm_src=010 -> immext=0xFFFFFFFC.
- instr=0x001000EF, imm_src=011 -> immext=0x00000800, rd=1. Then instr=0x123451B7, imm_src=100 -> immext=0x12345000. Then imm_src=110 -> immext=0, imm_err=1.
- XLEN=64: instr=0x800001B7, imm_src=100 -> immext=0xFFFFFFFF80000000. Then instr=0x0002D073, imm_src=101 -> immext=0x5.
- SKID=1, out_ready held 0, in_valid held 1 with instructions A, B, C:
  - A and B are accepted; in_ready=0 from the cycle after B is accepted; C is stalled.
  - Release out_ready: outputs A, B, C in order, one per cycle, with no bubble.
  - SKID=0: in_ready tracks out_ready combinationally.
- With 2 entries buffered, pulse reset_n low mid-cycle -> out_valid=0 and all outputs 0 immediately (asynchronously). After release, in_ready=1 and the first new instruction decodes correctly.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Registered RISC-V instruction-decode stage.
// Takes a 32-bit instruction and an immediate-format select over valid/ready.
// Presents the register indices, the opcode fields and the XLEN-wide extended
// immediate from a register, with optional skid storage for full throughput.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. The producer holds valid and its payload until that edge. While
// out_valid & !out_ready, every output stays unchanged.
//
// XLEN must be 32 or 64.
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] immext,
    output logic            imm_err,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // The raw instruction is kept so that the field outputs are plain slices.
    typedef struct packed {
        logic [31:0]     instr;
        logic            err;
        logic [XLEN-1:0] imm;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      main_q, skid_q, new_entry;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        live_q;
    logic [31:0] imm32;
    logic        src_err;
    logic        accept, consume;

    // Builds the 32-bit immediate. Zero-extension is done with a clear top bit,
    // so one sign-extension step covers every format at either XLEN.
    always_comb begin
        imm32   = 32'd0;
        src_err = 1'b0;
        case (imm_src)
            3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100:  imm32 = {instr[31:12], 12'd0};
            3'b101:  imm32 = {27'd0, instr[19:15]};
            default: src_err = 1'b1;
        endcase
    end

    assign new_entry.instr = instr;
    assign new_entry.err   = src_err;
    assign new_entry.imm   = XLEN'($signed(imm32));

    // With the skid entry, in_ready comes from a register. Without it, a full
    // register may refill on the same edge that drains it. live_q keeps
    // in_ready low until the first edge after reset.
    assign in_ready = (SKID != 0) ? in_ready_q : (live_q & (!out_valid_q | out_ready));
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid_q & out_ready;

    // Next occupancy, from the handshakes seen on the coming edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !consume)      state_d = (SKID != 0) ? ST_TWO : ST_ONE;
                else if (!accept && consume) state_d = ST_EMPTY;
            end
            ST_TWO:   if (consume) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Occupancy FSM with its registered flags and the main/skid entry moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            live_q      <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
            live_q      <= 1'b1;
            case (state_q)
                ST_EMPTY: if (accept) main_q <= new_entry;
                ST_ONE: begin
                    // Both handshakes: the new entry replaces main directly.
                    // Accept alone: the new entry parks in skid behind main.
                    if (accept && consume) main_q <= new_entry;
                    else if (accept)       skid_q <= new_entry;
                end
                ST_TWO:   if (consume) main_q <= skid_q;
                default:  ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = main_q.instr[6:0];
    assign rd        = main_q.instr[11:7];
    assign funct3    = main_q.instr[14:12];
    assign rs1       = main_q.instr[19:15];
    assign rs2       = main_q.instr[24:20];
    assign funct7    = main_q.instr[31:25];
    assign immext    = main_q.imm;
    assign imm_err   = main_q.err;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage. Three instances share one stimulus:
// a = RV32 with skid, b = RV64 with skid, c = RV32 single register.
module tb_imm_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_imm_err;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3;
    logic [31:0] a_immext;
    logic [1:0]  a_dbg_state;

    logic        b_in_ready, b_out_valid, b_imm_err;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic [63:0] b_immext;
    logic [1:0]  b_dbg_state;

    logic        c_in_ready, c_out_valid, c_imm_err;
    logic [6:0]  c_opcode, c_funct7;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [2:0]  c_funct3;
    logic [31:0] c_immext;
    logic [1:0]  c_dbg_state;

    imm_decode_stage #(.XLEN(32), .SKID(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid), .out_ready(out_ready),
        .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3), .rs1(a_rs1), .rs2(a_rs2),
        .funct7(a_funct7), .immext(a_immext), .imm_err(a_imm_err), .dbg_state(a_dbg_state)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(b_out_valid), .out_ready(out_ready),
        .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2),
        .funct7(b_funct7), .immext(b_immext), .imm_err(b_imm_err), .dbg_state(b_dbg_state)
    );

    imm_decode_stage #(.XLEN(32), .SKID(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(c_out_valid), .out_ready(out_ready),
        .opcode(c_opcode), .rd(c_rd), .funct3(c_funct3), .rs1(c_rs1), .rs2(c_rs2),
        .funct7(c_funct7), .immext(c_immext), .imm_err(c_imm_err), .dbg_state(c_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp;

        // Hand-decoded vectors: fields and immediates worked out from the bit patterns.
        vecs[0]  = '{32'hFFF10093, 3'b000, 7'h13, 5'd1,  3'd0, 5'd2,  5'd31, 7'h7F, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h00512423, 3'b001, 7'h23, 5'd8,  3'd2, 5'd2,  5'd5,  7'h00, 64'h0000000000000008, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 3'b010, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h001000EF, 3'b011, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd1,  7'h00, 64'h0000000000000800, 1'b0};
        vecs[4]  = '{32'h123451B7, 3'b100, 7'h37, 5'd3,  3'd5, 5'd8,  5'd3,  7'h09, 64'h0000000012345000, 1'b0};
        vecs[5]  = '{32'h123451B7, 3'b110, 7'h37, 5'd3,  3'd5, 5'd8,  5'd3,  7'h09, 64'h0000000000000000, 1'b1};
        vecs[6]  = '{32'h800001B7, 3'b100, 7'h37, 5'd3,  3'd0, 5'd0,  5'd0,  7'h40, 64'hFFFFFFFF80000000, 1'b0};
        vecs[7]  = '{32'h0002D073, 3'b101, 7'h73, 5'd0,  3'd5, 5'd5,  5'd0,  7'h00, 64'h0000000000000005, 1'b0};
        vecs[8]  = '{32'hFFF10093, 3'b111, 7'h13, 5'd1,  3'd0, 5'd2,  5'd31, 7'h7F, 64'h0000000000000000, 1'b1};
        vecs[9]  = '{32'h7FF00013, 3'b000, 7'h13, 5'd0,  3'd0, 5'd0,  5'd31, 7'h3F, 64'h00000000000007FF, 1'b0};
        vecs[10] = '{32'h800FD073, 3'b101, 7'h73, 5'd0,  3'd5, 5'd31, 5'd0,  7'h40, 64'h000000000000001F, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; instr = 32'd0; imm_src = 3'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_out_valid", 64'(a_out_valid), 0);
        chk("rst_a_in_ready", 64'(a_in_ready), 0);
        chk("rst_c_in_ready", 64'(c_in_ready), 0);
        chk("rst_a_immext", 64'(a_immext), 0);
        chk("rst_b_immext", b_immext, 0);
        chk("rst_a_imm_err", 64'(a_imm_err), 0);
        chk("rst_a_opcode", 64'(a_opcode), 0);
        reset_n = 1'b1;
        #1 chk("rst_rel_a_in_ready_low", 64'(a_in_ready), 0);
        @(negedge clk);
        chk("rst_rel_a_in_ready", 64'(a_in_ready), 1);
        chk("rst_rel_c_in_ready", 64'(c_in_ready), 1);

        // Table: one vector per cycle, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; instr = vecs[i].instr; imm_src = vecs[i].src;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_a_valid", i), 64'(a_out_valid), 1);
            chk($sformatf("v%0d_a_opcode", i), 64'(a_opcode), 64'(vecs[i].opc));
            chk($sformatf("v%0d_a_rd", i), 64'(a_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_a_funct3", i), 64'(a_funct3), 64'(vecs[i].f3));
            chk($sformatf("v%0d_a_rs1", i), 64'(a_rs1), 64'(vecs[i].rs1));
            chk($sformatf("v%0d_a_rs2", i), 64'(a_rs2), 64'(vecs[i].rs2));
            chk($sformatf("v%0d_a_funct7", i), 64'(a_funct7), 64'(vecs[i].f7));
            chk($sformatf("v%0d_a_immext", i), 64'(a_immext), 64'(vecs[i].imm[31:0]));
            chk($sformatf("v%0d_a_imm_err", i), 64'(a_imm_err), 64'(vecs[i].err));
            chk($sformatf("v%0d_b_immext", i), b_immext, vecs[i].imm);
            chk($sformatf("v%0d_b_imm_err", i), 64'(b_imm_err), 64'(vecs[i].err));
            chk($sformatf("v%0d_c_valid", i), 64'(c_out_valid), 1);
            chk($sformatf("v%0d_c_immext", i), 64'(c_immext), 64'(vecs[i].imm[31:0]));
        end
        @(negedge clk);
        chk("tbl_drained", 64'(a_out_valid), 0);

        // Skid: A, B accepted under backpressure, C stalls, then drained in order.
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'b000;
        instr = 32'h00100093; exp_q.push_back(64'd1);
        @(negedge clk);
        chk("skid_a_in_ready", 64'(a_in_ready), 1);
        chk("skid_a_valid", 64'(a_out_valid), 1);
        instr = 32'h00200093; exp_q.push_back(64'd2);
        @(negedge clk);
        chk("skid_full_in_ready", 64'(a_in_ready), 0);
        chk("skid_full_b_in_ready", 64'(b_in_ready), 0);
        chk("skid_hold_imm", 64'(a_immext), 1);
        instr = 32'h00300093; exp_q.push_back(64'd3);
        @(negedge clk);
        chk("skid_stall_in_ready", 64'(a_in_ready), 0);
        chk("skid_stall_valid", 64'(a_out_valid), 1);
        chk("skid_stall_imm", 64'(a_immext), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            chk($sformatf("drain%0d_valid", k), 64'(a_out_valid), 1);
            chk($sformatf("drain%0d_imm", k), 64'(a_immext), exp);
            chk($sformatf("drain%0d_b_imm", k), b_immext, exp);
            if (k == 2) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("skid_drain_empty", 64'(a_out_valid), 0);

        // Single register: in_ready follows out_ready; accept+consume replaces.
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00400093;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sk0_valid", 64'(c_out_valid), 1);
        chk("sk0_imm", 64'(c_immext), 4);
        chk("sk0_in_ready_low", 64'(c_in_ready), 0);
        out_ready = 1'b1;
        #1 chk("sk0_in_ready_high", 64'(c_in_ready), 1);
        in_valid = 1'b1; instr = 32'h00500093;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sk0_replace_valid", 64'(c_out_valid), 1);
        chk("sk0_replace_imm", 64'(c_immext), 5);
        @(negedge clk);
        chk("sk0_empty", 64'(c_out_valid), 0);

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF10093; imm_src = 3'b110;
        @(negedge clk);
        instr = 32'h00200093; imm_src = 3'b000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_state", 64'(a_dbg_state), 2);
        chk("pre_rst_err", 64'(a_imm_err), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(a_out_valid), 0);
        chk("async_rst_in_ready", 64'(a_in_ready), 0);
        chk("async_rst_imm", 64'(a_immext), 0);
        chk("async_rst_err", 64'(a_imm_err), 0);
        chk("async_rst_opcode", 64'(a_opcode), 0);
        chk("async_rst_rd", 64'(a_rd), 0);
        chk("async_rst_rs2", 64'(a_rs2), 0);
        chk("async_rst_funct7", 64'(a_funct7), 0);
        chk("async_rst_state", 64'(a_dbg_state), 0);
        chk("async_rst_b_imm", b_immext, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(a_in_ready), 1);
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h800001B7; imm_src = 3'b100;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(a_out_valid), 1);
        chk("post_rst_opcode", 64'(a_opcode), 64'h37);
        chk("post_rst_rd", 64'(a_rd), 3);
        chk("post_rst_imm", 64'(a_immext), 64'h80000000);
        chk("post_rst_b_imm", b_immext, 64'hFFFFFFFF80000000);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
